// File: rtl/pcie_msi_sched.sv
// Round-robin MSI scheduler: latches rising edges of up to 32 interrupt sources into
// pending bits and issues them one at a time to the PCIe hard IP with req/ack and holdoff spacing.
module pcie_msi_sched #(
  parameter int NUM_VEC   = 8,
  parameter int HOLDOFF_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_VEC-1:0]   irq,
  input  logic                 msi_enable,
  input  logic [NUM_VEC-1:0]   vec_mask,
  input  logic [HOLDOFF_W-1:0] holdoff,
  output logic                 app_msi_req,
  output logic [4:0]           app_msi_num,
  output logic [2:0]           app_msi_tc,
  output logic                 app_int_sts,
  input  logic                 app_msi_ack,
  output logic [NUM_VEC-1:0]   pending,
  output logic [31:0]          msi_sent
);

  localparam int IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t               state_q, state_d;
  logic [NUM_VEC-1:0]   irq_r_q, irq_r_d;
  logic [NUM_VEC-1:0]   pending_q, pending_d;
  logic                 req_q, req_d;
  logic [4:0]           num_q, num_d;
  logic [4:0]           last_grant_q, last_grant_d;
  logic [31:0]          sent_q, sent_d;
  logic [HOLDOFF_W-1:0] hold_q, hold_d;

  logic [NUM_VEC-1:0]   rise;
  logic [NUM_VEC-1:0]   elig;
  logic [NUM_VEC-1:0]   clr;
  logic [5:0]           cand;
  logic                 grant_found;
  logic [4:0]           grant_idx;
  logic                 grant_fire;
  logic                 ack_fire;

  // Search last_grant+1 .. last_grant+NUM_VEC (mod NUM_VEC); the first eligible hit wins.
  always_comb begin
    elig        = pending_q & ~vec_mask;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_VEC; k++) begin
      cand = {1'b0, last_grant_q} + 6'(k);
      if (cand >= 6'(NUM_VEC)) cand = cand - 6'(NUM_VEC);
      if (!grant_found && elig[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[4:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (msi_enable && grant_found) state_d = S_REQ;
      S_REQ:  if (app_msi_ack) state_d = (holdoff != '0) ? S_HOLD : S_IDLE;
      S_HOLD: if (hold_q <= HOLDOFF_W'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    grant_fire = (state_q == S_IDLE) && msi_enable && grant_found;
    ack_fire   = (state_q == S_REQ) && app_msi_ack;
  end

  // Datapath next values; a fresh edge on the granted vector survives the clear.
  always_comb begin
    irq_r_d      = irq;
    rise         = irq & ~irq_r_q & {NUM_VEC{msi_enable}};
    clr          = grant_fire ? (NUM_VEC'(1) << grant_idx) : '0;
    pending_d    = msi_enable ? ((pending_q & ~clr) | rise) : '0;
    req_d        = req_q;
    num_d        = num_q;
    last_grant_d = last_grant_q;
    sent_d       = sent_q;
    hold_d       = hold_q;
    if (grant_fire) begin
      req_d = 1'b1;
      num_d = grant_idx;
    end
    if (ack_fire) begin
      req_d        = 1'b0;
      last_grant_d = num_q;
      sent_d       = sent_q + 32'd1;
      hold_d       = holdoff;
    end else if (state_q == S_HOLD && hold_q != '0) begin
      hold_d = hold_q - HOLDOFF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_r_q      <= '0;
      pending_q    <= '0;
      req_q        <= 1'b0;
      num_q        <= '0;
      last_grant_q <= 5'(NUM_VEC - 1);
      sent_q       <= '0;
      hold_q       <= '0;
    end else begin
      irq_r_q      <= irq_r_d;
      pending_q    <= pending_d;
      req_q        <= req_d;
      num_q        <= num_d;
      last_grant_q <= last_grant_d;
      sent_q       <= sent_d;
      hold_q       <= hold_d;
    end
  end

  assign app_msi_req = req_q;
  assign app_msi_num = num_q;
  assign app_msi_tc  = 3'd0;
  assign app_int_sts = 1'b0;
  assign pending     = pending_q;
  assign msi_sent    = sent_q;

endmodule

// File: tb/tb_pcie_msi_sched.sv
// Directed bench for pcie_msi_sched (NUM_VEC=8): latency, round-robin order, holdoff,
// masking/merge, level hold, enable flush and reset during a handshake.
module tb_pcie_msi_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq;
  logic        msi_enable;
  logic [7:0]  vec_mask;
  logic [15:0] holdoff;
  logic        app_msi_req;
  logic [4:0]  app_msi_num;
  logic [2:0]  app_msi_tc;
  logic        app_int_sts;
  logic        app_msi_ack;
  logic [7:0]  pending;
  logic [31:0] msi_sent;

  int errors = 0;
  int checks = 0;
  int exp_sent = 0;

  pcie_msi_sched #(.NUM_VEC(8), .HOLDOFF_W(16)) dut (
    .clk(clk), .reset(reset), .irq(irq), .msi_enable(msi_enable), .vec_mask(vec_mask),
    .holdoff(holdoff), .app_msi_req(app_msi_req), .app_msi_num(app_msi_num),
    .app_msi_tc(app_msi_tc), .app_int_sts(app_int_sts), .app_msi_ack(app_msi_ack),
    .pending(pending), .msi_sent(msi_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int max, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (n < max && !ok) begin
      tick();
      n++;
      if (app_msi_req) ok = 1'b1;
    end
  endtask

  task automatic do_ack();
    app_msi_ack = 1'b1;
    tick();
    app_msi_ack = 1'b0;
    exp_sent++;
  endtask

  task automatic grant_and_ack(output logic [4:0] num, output bit ok);
    int n;
    wait_req(20, ok, n);
    num = app_msi_num;
    if (ok) do_ack();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_sent = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (app_msi_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h exp 0", app_msi_req); end
    checks++; if (app_msi_num !== 5'd0) begin errors++; $display("FAIL rst_num got %0h exp 0", app_msi_num); end
    checks++; if (app_msi_tc !== 3'd0 || app_int_sts !== 1'b0) begin errors++; $display("FAIL rst_tc_sts got %0h/%0h exp 0/0", app_msi_tc, app_int_sts); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rst_pending got %0h exp 0", pending); end
    checks++; if (msi_sent !== 32'd0) begin errors++; $display("FAIL rst_sent got %0d exp 0", msi_sent); end
  endtask

  task automatic test_single();
    holdoff = 16'd0;
    irq = 8'h04;
    tick();
    irq = 8'h00;
    checks++; if (pending !== 8'h04 || app_msi_req !== 1'b0) begin errors++; $display("FAIL single_pend got %0h/%0h exp 04/0", pending, app_msi_req); end
    tick();
    checks++; if (app_msi_req !== 1'b1 || app_msi_num !== 5'd2) begin errors++; $display("FAIL single_req got %0h/%0d exp 1/2", app_msi_req, app_msi_num); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL single_clr got %0h exp 0", pending); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (app_msi_req !== 1'b1 || app_msi_num !== 5'd2) begin errors++; $display("FAIL single_hold%0d got %0h/%0d exp 1/2", i, app_msi_req, app_msi_num); end
    end
    do_ack();
    checks++; if (app_msi_req !== 1'b0) begin errors++; $display("FAIL single_ackreq got %0h exp 0", app_msi_req); end
    checks++; if (msi_sent !== 32'd1) begin errors++; $display("FAIL single_sent got %0d exp 1", msi_sent); end
  endtask

  task automatic test_fairness();
    logic [4:0] num;
    bit ok;
    logic [4:0] exp_ord [6];
    exp_ord = '{5'd0, 5'd3, 5'd5, 5'd0, 5'd3, 5'd5};
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      irq = 8'h29;
      tick();
      irq = 8'h00;
      for (int j = 0; j < 3; j++) begin
        grant_and_ack(num, ok);
        checks++; if (!ok || num !== exp_ord[r*3+j]) begin errors++; $display("FAIL rr_order%0d ok=%0d got %0d exp %0d", r*3+j, ok, num, exp_ord[r*3+j]); end
      end
    end
    irq = 8'h08;
    tick();
    irq = 8'h00;
    grant_and_ack(num, ok);
    checks++; if (!ok || num !== 5'd3) begin errors++; $display("FAIL rr_set3 ok=%0d got %0d exp 3", ok, num); end
    irq = 8'h28;
    tick();
    irq = 8'h00;
    grant_and_ack(num, ok);
    checks++; if (!ok || num !== 5'd5) begin errors++; $display("FAIL rr_after3_first ok=%0d got %0d exp 5", ok, num); end
    grant_and_ack(num, ok);
    checks++; if (!ok || num !== 5'd3) begin errors++; $display("FAIL rr_after3_second ok=%0d got %0d exp 3", ok, num); end
    checks++; if (msi_sent !== 32'(exp_sent)) begin errors++; $display("FAIL rr_sent got %0d exp %0d", msi_sent, exp_sent); end
  endtask

  task automatic test_holdoff();
    bit ok;
    int n;
    holdoff = 16'd10;
    irq = 8'h12;
    tick();
    irq = 8'h00;
    wait_req(20, ok, n);
    checks++; if (!ok || app_msi_num !== 5'd4) begin errors++; $display("FAIL hold_first ok=%0d got %0d exp 4", ok, app_msi_num); end
    do_ack();
    n = 0;
    while (!app_msi_req && n < 30) begin
      tick();
      n++;
    end
    checks++; if (n !== 11) begin errors++; $display("FAIL hold_gap got %0d exp 11", n); end
    checks++; if (app_msi_num !== 5'd1) begin errors++; $display("FAIL hold_second got %0d exp 1", app_msi_num); end
    if (app_msi_req) do_ack();
    holdoff = 16'd0;
    repeat (12) tick();
  endtask

  task automatic test_mask_merge();
    logic [4:0] num;
    bit ok;
    bit saw_req = 1'b0;
    int n;
    vec_mask = 8'h40;
    for (int i = 0; i < 3; i++) begin
      irq = 8'h40;
      tick();
      saw_req |= app_msi_req;
      irq = 8'h00;
      tick();
      saw_req |= app_msi_req;
      tick();
      saw_req |= app_msi_req;
    end
    checks++; if (saw_req !== 1'b0) begin errors++; $display("FAIL mask_noreq got %0d exp 0", saw_req); end
    checks++; if (pending !== 8'h40) begin errors++; $display("FAIL mask_pend got %0h exp 40", pending); end
    vec_mask = 8'h00;
    grant_and_ack(num, ok);
    checks++; if (!ok || num !== 5'd6) begin errors++; $display("FAIL mask_unmask ok=%0d got %0d exp 6", ok, num); end
    wait_req(10, ok, n);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL mask_once extra req got %0d exp 0", ok); end
    checks++; if (msi_sent !== 32'(exp_sent)) begin errors++; $display("FAIL mask_sent got %0d exp %0d", msi_sent, exp_sent); end
  endtask

  task automatic test_level_enable();
    int reqs = 0;
    bit ok;
    int n;
    irq = 8'h02;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (app_msi_ack) begin
        app_msi_ack = 1'b0;
      end else if (app_msi_req) begin
        reqs++;
        exp_sent++;
        app_msi_ack = 1'b1;
      end
    end
    app_msi_ack = 1'b0;
    irq = 8'h00;
    tick();
    checks++; if (reqs !== 1) begin errors++; $display("FAIL level_once got %0d exp 1", reqs); end
    vec_mask = 8'h80;
    irq = 8'h80;
    tick();
    irq = 8'h00;
    tick();
    checks++; if (pending !== 8'h80) begin errors++; $display("FAIL en_prepend got %0h exp 80", pending); end
    msi_enable = 1'b0;
    tick();
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL en_flush got %0h exp 0", pending); end
    vec_mask = 8'h00;
    irq = 8'h80;
    tick();
    irq = 8'h00;
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL en_ignore got %0h exp 0", pending); end
    wait_req(5, ok, n);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL en_noreq got %0d exp 0", ok); end
    msi_enable = 1'b1;
    wait_req(10, ok, n);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL en_reenable got %0d exp 0", ok); end
    app_msi_ack = 1'b1;
    tick();
    app_msi_ack = 1'b0;
    checks++; if (msi_sent !== 32'(exp_sent)) begin errors++; $display("FAIL stray_ack sent got %0d exp %0d", msi_sent, exp_sent); end
  endtask

  task automatic test_reset_midreq();
    logic [4:0] num;
    bit ok;
    int n;
    irq = 8'h01;
    tick();
    irq = 8'h00;
    wait_req(10, ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_req got %0d exp 1", ok); end
    reset = 1'b1;
    tick();
    checks++; if (app_msi_req !== 1'b0 || app_msi_num !== 5'd0) begin errors++; $display("FAIL midrst_out got %0h/%0d exp 0/0", app_msi_req, app_msi_num); end
    checks++; if (pending !== 8'h00 || msi_sent !== 32'd0) begin errors++; $display("FAIL midrst_state got %0h/%0d exp 0/0", pending, msi_sent); end
    reset = 1'b0;
    exp_sent = 0;
    wait_req(10, ok, n);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL midrst_dropped got %0d exp 0", ok); end
    irq = 8'h09;
    tick();
    irq = 8'h00;
    grant_and_ack(num, ok);
    checks++; if (!ok || num !== 5'd0) begin errors++; $display("FAIL midrst_last ok=%0d got %0d exp 0", ok, num); end
    grant_and_ack(num, ok);
    checks++; if (!ok || num !== 5'd3) begin errors++; $display("FAIL midrst_next ok=%0d got %0d exp 3", ok, num); end
    checks++; if (msi_sent !== 32'd2) begin errors++; $display("FAIL midrst_sent got %0d exp 2", msi_sent); end
  endtask

  initial begin
    reset       = 1'b1;
    irq         = 8'h00;
    msi_enable  = 1'b1;
    vec_mask    = 8'h00;
    holdoff     = 16'd0;
    app_msi_ack = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_holdoff();
    test_mask_merge();
    test_level_enable();
    test_reset_midreq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcie_msi_sched.md
# pcie_msi_sched

Round-robin MSI scheduler between up to 32 level-style interrupt sources and the PCIe hard IP MSI interface (`app_msi_*`). Each source's rising edges are latched into a per-vector pending bit. Pending vectors are granted fairly, one at a time, with a full req/ack handshake. A programmable holdoff spaces consecutive MSIs to moderate host interrupt load. Per-vector masking and a global enable come from the driver-visible CSR block.

## Interface
Parameters:
- `NUM_VEC`, default 8: number of interrupt sources/vectors, legal range 1..32.
- `HOLDOFF_W`, default 16: width of the holdoff counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `irq`  in  `NUM_VEC`  interrupt sources. A rising edge requests one MSI.
- `msi_enable`  in  1  global enable from config/CSR. Low flushes and ignores sources.
- `vec_mask`  in  `NUM_VEC`  1 = vector masked: stays pending but is not sent.
- `holdoff`  in  `HOLDOFF_W`  minimum idle cycles after each ack before the next request.
- `app_msi_req`  out  1  MSI request to hard IP.
- `app_msi_num`  out  5  MSI vector number, zero-extended grant index.
- `app_msi_tc`  out  3  traffic class, constant 0.
- `app_int_sts`  out  1  legacy INTx status, constant 0.
- `app_msi_ack`  in  1  hard IP accepted the request. Single-cycle pulse.
- `pending`  out  `NUM_VEC`  current pending bits, for CSR readback.
- `msi_sent`  out  32  count of acked MSIs. Wraps at 2^32.

## Operation
- Edge detect: `irq_r` is updated from `irq` every cycle. Bit i sets `pending[i]` when `irq[i] & ~irq_r[i] & msi_enable`. A held-high level does not retrigger.
- A new edge on a vector that is already pending merges into the existing bit (coalesced, not counted).
- `msi_enable` low: `pending` is cleared every cycle and no new grant is issued.
- Eligible set = `pending & ~vec_mask`.
- FSM states: IDLE, REQ, HOLD.
- IDLE → REQ when `msi_enable` and the eligible set is non-zero.
  - Grant = the first eligible index searching `last_grant+1`, `last_grant+2`, …, wrapping modulo `NUM_VEC`.
  - The grant is latched into `app_msi_num`, `app_msi_req` is set to 1, and the granted pending bit is cleared.
  - In the same cycle, a new edge on the granted vector takes priority (set beats clear).
- REQ: `app_msi_req` and `app_msi_num` are held stable until `app_msi_ack`. Changes to mask or enable do not abort the handshake.
  - On ack: `app_msi_req` goes to 0, `last_grant` is set to the grant, `msi_sent` increments, and the holdoff counter loads `holdoff`.
  - Next state is HOLD if `holdoff != 0`, else IDLE.
- HOLD: counter decrements by 1 each cycle. At 1, the next state is IDLE. Edges continue to be latched during HOLD.
- `app_msi_ack` outside REQ is ignored.

## Timing
- Reset values: `app_msi_req=0`, `app_msi_num=0`, `app_msi_tc=0`, `app_int_sts=0`, `pending=0`, `msi_sent=0`, `irq_r=0`, `last_grant=NUM_VEC-1` (vector 0 wins first), state IDLE.
- Reset asserted mid-REQ: `app_msi_req` is low after the next clock edge, and the outstanding request is dropped.
- Latency, edge to request: `irq` rises before edge t, so `pending` is set after edge t and `app_msi_req` is high after edge t+1, provided the FSM is IDLE.
- Ack at edge a: `app_msi_req` is low after edge a. The earliest next request is high after edge a+1 (`holdoff=0`) or after edge a+`holdoff`+1.
- All outputs are registered. No combinational path exists from inputs to outputs.
- `NUM_VEC=1`: round-robin degenerates to a single vector. `app_msi_num` is always 0.

## Test plan
- Single source: pulse `irq[2]` for one cycle with `holdoff=0`, ack 3 cycles after req → req high 2 clocks after the edge, `app_msi_num=2` held stable until ack, `pending=0` after grant, `msi_sent=1`.
- Fairness: edges on vectors 0, 3 and 5 in the same cycle, immediate acks → grant order 0, 3, 5. Then re-pulse all three with `last_grant=5` → grant order 0, 3, 5 again. Pulse 3 and 5 with `last_grant=3` → grant 5 first.
- Holdoff: `holdoff=10`, vectors 1 and 4 pending → second req rises exactly 11 clocks after the first ack.
- Mask and merge: `vec_mask[6]=1`, pulse `irq[6]` three times → no req, `pending[6]=1`. Unmask → exactly one MSI with num=6.
- Level hold and enable: hold `irq[1]` high for 100 cycles → exactly one MSI. With `msi_enable=0`, pulse `irq[7]` → no req and `pending=0`. Re-enable → no MSI.
- Reset mid-REQ: assert reset while req is high and unacked → req low after 1 clock, all state at reset values, and no MSI after reset deasserts.
